scarv_cop_malu_seq: RTL

Parametrised, multi-cycle successor to the combinational multi-precision ALU in the SCARV crypto co-processor. It executes the multi-precision add, subtract, double-word shift, multiply-accumulate and carry-less multiply instructions, and produces a 2·XLEN result for register-pair writeback. Multiplies are iterative, MUL_STEP bits per cycle, so area and latency can be traded. The block sits between the co-processor decode/register-read stage and the CPR writeback mux, and uses a valid/done handshake with an abort (flush) input.

---
 rtl/scarv_cop_malu_seq_if.sv | 28 ++
 rtl/scarv_cop_malu_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/scarv_cop_malu_seq_if.sv
// Request/response bundle between co-processor decode and the multi-cycle MP ALU.
// The slave modport is the ALU side; the master modport is the decode/writeback side.
interface scarv_cop_malu_seq_if #(
  parameter int XLEN = 32
) ();
  logic                        ivalid;
  logic                        idone;
  logic                        flush;
  logic [3:0]                  op;
  logic [XLEN-1:0]             rs1;
  logic [XLEN-1:0]             rs2;
  logic [XLEN-1:0]             rs3;
  logic [$clog2(2*XLEN)-1:0]   shamt;
  logic                        rdone;
  logic [2*XLEN-1:0]           rd_wdata;
  logic                        busy;
  logic                        bad_op;

  modport slave (
    input  ivalid, idone, flush, op, rs1, rs2, rs3, shamt,
    output rdone, rd_wdata, busy, bad_op
  );

  modport master (
    output ivalid, idone, flush, op, rs1, rs2, rs3, shamt,
    input  rdone, rd_wdata, busy, bad_op
  );
endinterface

// File: rtl/scarv_cop_malu_seq.sv
// Multi-cycle multi-precision ALU: add/sub/double-word shift in one cycle,
// multiply-accumulate and carry-less multiply iterated MUL_STEP bits per cycle.
//
// state | meaning
// IDLE  | waiting for a request
// EXEC  | iterating a multiply, one MUL_STEP-bit slice of rs2 per edge
// DONE  | result held on rd_wdata until idone (or flush)
module scarv_cop_malu_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  scarv_cop_malu_seq_if.slave  malu
);

  localparam int N  = XLEN / MUL_STEP;
  localparam int CW = $clog2(N) + 1;
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            accept;
  logic            is_mul;
  logic            last_step;
  logic [CW-1:0]   step;
  logic            clmul_q;
  logic [W2-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   acc_nxt;
  logic [W2-1:0]   single_res;
  logic            single_bad;
  logic            borrow_in;
  logic [XLEN:0]   diff;
  logic [W2-1:0]   rd_wdata_q;
  logic            bad_op_q;

  assign is_mul    = (malu.op[3:1] == 3'b011);
  assign accept    = malu.ivalid && !malu.flush &&
                     ((state == IDLE) || ((state == DONE) && malu.idone));
  assign last_step = (state == EXEC) && (step == CW'(N - 1));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (malu.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = is_mul ? EXEC : DONE;
        end
        EXEC: begin
          if (last_step) state_nxt = DONE;
        end
        DONE: begin
          if (accept)          state_nxt = is_mul ? EXEC : DONE;
          else if (malu.idone) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    malu.busy     = (state != IDLE);
    malu.rdone    = (state == DONE);
    malu.rd_wdata = rd_wdata_q;
    malu.bad_op   = bad_op_q;
  end

  // Subtraction is done XLEN+1 wide so the top bit is exactly the borrow out.
  always_comb begin
    single_res = '0;
    single_bad = 1'b0;
    borrow_in  = (malu.op == 4'd3) && malu.rs3[0];
    diff       = {1'b0, malu.rs1} - {1'b0, malu.rs2} - {{XLEN{1'b0}}, borrow_in};
    case (malu.op)
      4'd0: single_res = {{XLEN{1'b0}}, malu.rs1} + {{XLEN{1'b0}}, malu.rs2};
      4'd1: single_res = {{XLEN{1'b0}}, malu.rs1} + {{XLEN{1'b0}}, malu.rs2}
                         + {{(W2-1){1'b0}}, malu.rs3[0]};
      4'd2,
      4'd3: single_res = {{(XLEN-1){1'b0}}, diff[XLEN], diff[XLEN-1:0]};
      4'd4: single_res = {malu.rs2, malu.rs1} << malu.shamt;
      4'd5: single_res = {malu.rs2, malu.rs1} >> malu.shamt;
      4'd6,
      4'd7: single_res = '0;
      default: single_bad = 1'b1;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) begin
        acc_nxt = clmul_q ? (acc_nxt ^ (mcand << j)) : (acc_nxt + (mcand << j));
      end
    end
  end

  // Flush drops the multiply in flight but leaves the last written result on rd_wdata.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      step       <= '0;
      clmul_q    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      rd_wdata_q <= '0;
      bad_op_q   <= 1'b0;
    end else if (malu.flush) begin
      step <= '0;
      acc  <= '0;
    end else if (accept) begin
      step     <= '0;
      clmul_q  <= malu.op[0];
      bad_op_q <= single_bad;
      if (is_mul) begin
        mcand  <= {{XLEN{1'b0}}, malu.rs1};
        mplier <= malu.rs2;
        acc    <= malu.op[0] ? '0 : {{XLEN{1'b0}}, malu.rs3};
      end else begin
        rd_wdata_q <= single_res;
      end
    end else if (state == EXEC) begin
      step   <= step + CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      if (last_step) rd_wdata_q <= acc_nxt;
    end
  end

endmodule
